cpu_instr_feeder: RTL and testbench

Host-side initiator for the `cpu` start/wait handshake. It buffers 16-bit instructions pushed by a host or testbench and issues them to the CPU one at a time: it drives `in`/`load`, pulses `s`, waits for `w` to fall and rise again, then captures `out` and the V/N/Z flags. It sits between a host write port and the CPU instance and turns the lab CPU into a queued execution engine.

---
 rtl/cpu_instr_feeder_if.sv | 53 +++++
 rtl/cpu_instr_feeder.sv | 186 ++++++++++++++++++
 tb/tb_cpu_instr_feeder.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_instr_feeder_if.sv
// Host and CPU signals of cpu_instr_feeder, bundled as one interface.
// master: the feeder itself. slave: the host/CPU side driving requests and CPU status.
// The err signal exists only when FEEDER_TIMEOUT_EN is defined.
interface cpu_instr_feeder_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    // Host write port and occupancy
    logic            wr_en;
    logic [15:0]     wr_data;
    logic            full;
    logic            empty;
    logic [CntW-1:0] count;

    // CPU start/wait handshake
    logic [15:0]     cpu_in;
    logic            cpu_load;
    logic            cpu_s;
    logic            cpu_w;
    logic [15:0]     cpu_out;
    logic            cpu_N;
    logic            cpu_V;
    logic            cpu_Z;

    // Completion reporting
    logic [15:0]     result;
    logic [2:0]      flags;
    logic            result_valid;
    logic            busy;
    logic [7:0]      done_cnt;
`ifdef FEEDER_TIMEOUT_EN
    logic            err;
`endif

    modport master (
        input  wr_en, wr_data, cpu_w, cpu_out, cpu_N, cpu_V, cpu_Z,
        output full, empty, count, cpu_in, cpu_load, cpu_s,
        output result, flags, result_valid, busy, done_cnt
`ifdef FEEDER_TIMEOUT_EN
        , output err
`endif
    );

    modport slave (
        output wr_en, wr_data, cpu_w, cpu_out, cpu_N, cpu_V, cpu_Z,
        input  full, empty, count, cpu_in, cpu_load, cpu_s,
        input  result, flags, result_valid, busy, done_cnt
`ifdef FEEDER_TIMEOUT_EN
        , input err
`endif
    );
endinterface

// File: rtl/cpu_instr_feeder.sv
// Queued instruction feeder for the lab CPU start/wait handshake.
// Buffers 16-bit instructions in a DEPTH-entry FIFO and issues them one at a time:
// load the instruction register, pulse s, wait for w to fall and rise, capture out/flags.
// Optional watchdog: define FEEDER_TIMEOUT_EN to abort an instruction that stalls for
// TIMEOUT cycles in START/WAITLO/WAITHI and raise a sticky err.
module cpu_instr_feeder #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    cpu_instr_feeder_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWaitLo,
        StWaitHi,
        StDone
    } state_e;

    state_e          state_q;

    logic [15:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            wd_hit;

    logic [15:0]     cpu_in_q;
    logic            cpu_load_q;
    logic            cpu_s_q;
    logic [15:0]     result_q;
    logic [2:0]      flags_q;
    logic            result_valid_q;
    logic [7:0]      done_cnt_q;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    // A push against a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign push  = bus.wr_en && !full;
    // The head leaves the FIFO on completion or on a watchdog abort.
    assign pop   = (state_q == StDone) || wd_hit;

`ifdef FEEDER_TIMEOUT_EN
    localparam int unsigned WdW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [WdW-1:0] wd_cnt_q;
    logic           err_q;

    assign wd_hit = (state_q inside {StStart, StWaitLo, StWaitHi}) &&
                    (wd_cnt_q == WdW'(TIMEOUT - 1));

    // Watchdog: count cycles spent waiting on the CPU, zeroed while idle; err is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                wd_cnt_q <= '0;
            end else if (state_q inside {StStart, StWaitLo, StWaitHi}) begin
                wd_cnt_q <= wd_cnt_q + WdW'(1);
            end
            if (wd_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    logic unused_timeout;

    assign wd_hit         = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Issue FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            cpu_in_q       <= '0;
            cpu_load_q     <= 1'b0;
            cpu_s_q        <= 1'b0;
            result_q       <= '0;
            flags_q        <= '0;
            result_valid_q <= 1'b0;
            done_cnt_q     <= '0;
        end else begin
            cpu_load_q     <= 1'b0;
            result_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!empty && bus.cpu_w) begin
                        cpu_in_q   <= mem_q[rd_ptr_q];
                        cpu_load_q <= 1'b1;
                        state_q    <= StLoad;
                    end
                end
                StLoad: begin
                    // s rises only after load has dropped so the instruction is latched first.
                    cpu_s_q <= 1'b1;
                    state_q <= StStart;
                end
                StStart: begin
                    state_q <= StWaitLo;
                end
                StWaitLo: begin
                    if (!bus.cpu_w) begin
                        cpu_s_q <= 1'b0;
                        state_q <= StWaitHi;
                    end
                end
                StWaitHi: begin
                    if (bus.cpu_w) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    result_q       <= bus.cpu_out;
                    flags_q        <= {bus.cpu_V, bus.cpu_N, bus.cpu_Z};
                    result_valid_q <= 1'b1;
                    done_cnt_q     <= done_cnt_q + 8'd1;
                    state_q        <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
            // Watchdog abort overrides normal progress: drop s and give up on this entry.
            if (wd_hit) begin
                cpu_s_q <= 1'b0;
                state_q <= StIdle;
            end
        end
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = count_q;
    assign bus.cpu_in       = cpu_in_q;
    assign bus.cpu_load     = cpu_load_q;
    assign bus.cpu_s        = cpu_s_q;
    assign bus.result       = result_q;
    assign bus.flags        = flags_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.done_cnt     = done_cnt_q;
endmodule

// File: tb/tb_cpu_instr_feeder.sv
// Directed bench for cpu_instr_feeder driving a small behavioural model of the lab CPU.
// Expected results and issue order are queued when words are pushed and checked as the
// DUT issues and completes them.
module tb_cpu_instr_feeder;
    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  vnz;
    } exp_t;

    logic clk;
    logic reset;

    cpu_instr_feeder_if #(.DEPTH(DEPTH)) bus ();

    cpu_instr_feeder #(
        .DEPTH  (DEPTH),
        .TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int rv_cnt = 0;

    exp_t        sb_q[$];
    logic [15:0] iss_q[$];
    exp_t        mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural CPU model ----------------
    logic        stub_w;
    logic [15:0] stub_out;
    logic [2:0]  stub_vnz;
    logic [15:0] ir;
    logic [15:0] regs [8];
    int          stub_st;
    int          stub_cnt;
    int          busy_len;
    bit          hold_w_low;
    bit          ignore_s;

    assign bus.cpu_w   = stub_w && !hold_w_low;
    assign bus.cpu_out = stub_out;
    assign bus.cpu_V   = stub_vnz[2];
    assign bus.cpu_N   = stub_vnz[1];
    assign bus.cpu_Z   = stub_vnz[0];

    function automatic logic [15:0] alu_val(input logic [15:0] i, input logic [15:0] a,
                                            input logic [15:0] b);
        if (i[15:13] == 3'b110) return {{8{i[7]}}, i[7:0]};
        return a + b;
    endfunction

    function automatic logic [2:0] add_vnz(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        s = a + b;
        return {(a[15] == b[15]) && (s[15] != a[15]), s[15], s == 16'h0000};
    endfunction

    // MOV Rn,#imm8 (110 10 Rn imm8) and ADD Rd,Rn,Rm (101 00 Rn Rd 00 Rm); w drops one
    // cycle after s is seen and returns busy_len+1 cycles later.
    always @(posedge clk) begin
        if (reset) begin
            stub_w   <= 1'b1;
            stub_st  <= 0;
            stub_cnt <= 0;
            stub_out <= '0;
            stub_vnz <= '0;
            ir       <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            if (bus.cpu_load) ir <= bus.cpu_in;
            case (stub_st)
                0: if (bus.cpu_s && !ignore_s) stub_st <= 1;
                1: begin
                    stub_w   <= 1'b0;
                    stub_cnt <= 0;
                    stub_st  <= 2;
                end
                default: begin
                    if (stub_cnt == busy_len) begin
                        stub_out <= alu_val(ir, regs[ir[10:8]], regs[ir[2:0]]);
                        if (ir[15:13] == 3'b110) begin
                            regs[ir[10:8]] <= alu_val(ir, regs[ir[10:8]], regs[ir[2:0]]);
                        end else begin
                            regs[ir[7:5]] <= alu_val(ir, regs[ir[10:8]], regs[ir[2:0]]);
                            stub_vnz      <= add_vnz(regs[ir[10:8]], regs[ir[2:0]]);
                        end
                        stub_w  <= 1'b1;
                        stub_st <= 0;
                    end else begin
                        stub_cnt <= stub_cnt + 1;
                    end
                end
            endcase
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!reset && bus.result_valid) begin
            rv_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", 32'(bus.result), 32'(mon_e.res));
                chk("flags", 32'(bus.flags), 32'(mon_e.vnz));
            end
        end
        if (!reset && bus.cpu_load) begin
            if (iss_q.size() == 0) chk("unexpected_load", 32'd1, 32'd0);
            else chk("issue_order", 32'(bus.cpu_in), 32'(iss_q.pop_front()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_word(input logic [15:0] w, input bit issued);
        bus.wr_en   = 1'b1;
        bus.wr_data = w;
        if (issued) iss_q.push_back(w);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic expect_res(input logic [15:0] res, input logic [2:0] vnz);
        exp_t e;
        e.res = res;
        e.vnz = vnz;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input logic [7:0] target);
        int n = 0;
        while (bus.done_cnt !== target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("done_cnt_reached", 32'(bus.done_cnt), 32'(target));
        @(negedge clk);
    endtask

    int rv_before;
    int n;

    initial begin
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        hold_w_low  = 1'b0;
        ignore_s    = 1'b0;
        busy_len    = 3;

        // Reset values
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_load", 32'(bus.cpu_load), 32'd0);
        chk("rst_s", 32'(bus.cpu_s), 32'd0);
        chk("rst_rv", 32'(bus.result_valid), 32'd0);
        chk("rst_done_cnt", 32'(bus.done_cnt), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_cpu_in", 32'(bus.cpu_in), 32'd0);
`ifdef FEEDER_TIMEOUT_EN
        chk("rst_err", 32'(bus.err), 32'd0);
`endif

        // Single MOV R0,#7: push-to-load latency and load/start ordering
        expect_res(16'h0007, 3'b000);
        push_word(16'hD007, 1'b1);
        chk("mov_count_after_push", 32'(bus.count), 32'd1);
        chk("mov_load_not_yet", 32'(bus.cpu_load), 32'd0);
        @(negedge clk);
        chk("mov_load_pulse", 32'(bus.cpu_load), 32'd1);
        chk("mov_cpu_in", 32'(bus.cpu_in), 32'hD007);
        chk("mov_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("mov_load_drop", 32'(bus.cpu_load), 32'd0);
        chk("mov_s_rise", 32'(bus.cpu_s), 32'd1);
        wait_done(8'd1);
        chk("mov_empty", 32'(bus.empty), 32'd1);
        chk("mov_rv_pulses", 32'(rv_cnt), 32'd1);
        chk("mov_idle", 32'(bus.busy), 32'd0);
        chk("mov_result_hold", 32'(bus.result), 32'h0007);

        // Queue order: MOV R0,#3; MOV R1,#5; ADD R3,R0,R1
        expect_res(16'h0003, 3'b000);
        expect_res(16'h0005, 3'b000);
        expect_res(16'h0008, 3'b000);
        push_word(16'hD003, 1'b1);
        push_word(16'hD105, 1'b1);
        push_word(16'hA061, 1'b1);
        wait_done(8'd4);
        chk("q_result", 32'(bus.result), 32'h0008);
        chk("q_flags", 32'(bus.flags), 32'd0);
        chk("q_rv_pulses", 32'(rv_cnt), 32'd4);
        chk("q_empty", 32'(bus.empty), 32'd1);

        // Overflow: CPU not ready, nine pushes, the ninth is dropped
        hold_w_low = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            expect_res(16'(16 + i), 3'b000);
            push_word(16'hD010 + 16'(i), 1'b1);
        end
        push_word(16'hD018, 1'b0);
        chk("ovf_count", 32'(bus.count), 32'd8);
        chk("ovf_full", 32'(bus.full), 32'd1);
        chk("ovf_busy", 32'(bus.busy), 32'd0);
        hold_w_low = 1'b0;
        wait_done(8'd12);
        repeat (30) @(negedge clk);
        chk("ovf_done_cnt", 32'(bus.done_cnt), 32'd12);
        chk("ovf_issue_left", 32'(iss_q.size()), 32'd0);
        chk("ovf_results_left", 32'(sb_q.size()), 32'd0);
        chk("ovf_empty", 32'(bus.empty), 32'd1);

        // Reset while in WAITHI discards the FIFO and the in-flight instruction
        busy_len = 20;
        push_word(16'hD02A, 1'b1);
        push_word(16'hD02B, 1'b0);
        n = 0;
        while (bus.cpu_s !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rmid_s_seen", 32'(bus.cpu_s), 32'd1);
        n = 0;
        while (!(bus.busy === 1'b1 && bus.cpu_s === 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rmid_in_waithi", 32'(bus.busy && !bus.cpu_s), 32'd1);
        chk("rmid_count_before", 32'(bus.count), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        iss_q.delete();
        rv_before = rv_cnt;
        chk("rmid_busy", 32'(bus.busy), 32'd0);
        chk("rmid_count", 32'(bus.count), 32'd0);
        chk("rmid_empty", 32'(bus.empty), 32'd1);
        chk("rmid_done_cnt", 32'(bus.done_cnt), 32'd0);
        chk("rmid_rv", 32'(bus.result_valid), 32'd0);
        repeat (40) @(negedge clk);
        chk("rmid_no_rv", 32'(rv_cnt), 32'(rv_before));
        chk("rmid_still_idle", 32'(bus.busy), 32'd0);
        chk("rmid_done_cnt_later", 32'(bus.done_cnt), 32'd0);
        busy_len = 3;

`ifdef FEEDER_TIMEOUT_EN
        // Watchdog: CPU never acknowledges s; err rises 16 cycles after START
        ignore_s = 1'b1;
        push_word(16'hD001, 1'b1);
        n = 0;
        while (bus.cpu_s !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wd_start_seen", 32'(bus.cpu_s), 32'd1);
        repeat (15) @(negedge clk);
        chk("wd_err_not_yet", 32'(bus.err), 32'd0);
        @(negedge clk);
        chk("wd_err_set", 32'(bus.err), 32'd1);
        chk("wd_s_dropped", 32'(bus.cpu_s), 32'd0);
        chk("wd_idle", 32'(bus.busy), 32'd0);
        chk("wd_popped", 32'(bus.count), 32'd0);
        chk("wd_done_cnt", 32'(bus.done_cnt), 32'd0);
        repeat (5) @(negedge clk);
        chk("wd_err_sticky", 32'(bus.err), 32'd1);
        chk("wd_no_rv", 32'(rv_cnt), 32'(rv_before));
        ignore_s = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case a wait is never satisfied by the stimulus itself
    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench did not finish");
    end
endmodule
